apb_cmd_master: RTL
===================

Name: apb_cmd_master

Overview:
APB3 initiator that turns a local valid/ready command stream into APB transfers toward CoreGPIO-class slaves, and returns one response per command. It is the master-side counterpart of the slave interfaces in our peripheral subsystem. It replaces the simulation BFM wherever synthesizable bus driving is needed, for example on-chip self-test or a bridge from a soft-core. It includes a command FIFO, a SETUP/ACCESS state machine, a PREADY timeout and a held response register.

Parameters:
ADDR_WIDTH, 8, width of PADDR and cmd_addr
DATA_WIDTH, 32, APB data width; legal values 8, 16, 32
CMD_DEPTH, 4, command FIFO entries; power of 2, minimum 2
TIMEOUT, 255, maximum ACCESS cycles waiting for PREADY; 0 disables the timeout

Ports:
PCLK  in  1  single clock; all logic on its rising edge
PRESETN  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept a command (not full)
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data; ignored for reads
rsp_valid  out  1  response held
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_err  out  1  PSLVERR seen, or timeout
rsp_timeout  out  1  transfer aborted by timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error
busy  out  1  FIFO non-empty, or state not IDLE, or rsp_valid

Behaviour:
- Reset: when PRESETN=0 at a PCLK edge, all of the following hold from the next edge:
  - FIFO flushed; state=IDLE; timeout counter=0.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0.
  - cmd_ready=0 while PRESETN=0 and 1 afterwards; busy=0.
  - A reset during ACCESS aborts the transfer with no response.
- FIFO:
  - Push on cmd_valid&cmd_ready; pop on entry to SETUP.
  - Simultaneous push and pop while full is not allowed, because cmd_ready depends only on the full flag.
  - Push into an empty FIFO is visible to the FSM on the next cycle.
  - Pointers wrap modulo CMD_DEPTH; a separate count distinguishes full from empty.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when FIFO non-empty and (rsp_valid=0 or rsp_ready=1). PSEL=1, PENABLE=0; PADDR, PWRITE and PWDATA are loaded from the FIFO head.
  - SETUP -> ACCESS unconditionally after one cycle. PSEL=1, PENABLE=1.
  - ACCESS with PREADY=1: complete; -> IDLE with PSEL=PENABLE=0.
    - rsp_valid=1 next cycle.
    - rsp_rdata = PRDATA for reads, 0 for writes.
    - rsp_err = PSLVERR sampled in that same cycle; rsp_timeout=0.
  - ACCESS with PREADY=0: stay; counter increments.
    - If TIMEOUT!=0 and the counter reaches TIMEOUT, abort: -> IDLE with PSEL=PENABLE=0.
    - Response: rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - The counter clears on entry to SETUP.
- PADDR, PWRITE and PWDATA are stable through SETUP and ACCESS and hold their last values in IDLE.
- PSLVERR is ignored except in the completing ACCESS cycle.
- Response register:
  - Loaded at completion or abort; cleared on rsp_valid&rsp_ready unless a new response loads in the same cycle.
  - It cannot be overwritten while held, because IDLE does not launch while a response is held and unconsumed.
- Latency and throughput:
  - Command accepted at edge N into an idle, empty block: SETUP at N+1, ACCESS at N+2.
  - With PREADY=1 in ACCESS, rsp_valid=1 at N+3.
  - Back-to-back throughput is 3 cycles per transfer (SETUP, ACCESS, IDLE) with rsp_ready held 1.
  - Each wait state adds 1 cycle.
- DATA_WIDTH narrower than the slave's register width is the integrator's concern; there is no byte steering.

Test Plan:
1. Write 0x000000A5 to addr 0x04 with PREADY tied 1 -> PSEL rises at N+1, PENABLE at N+2 with PADDR=0x04, PWRITE=1, PWDATA=0xA5; rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
2. Read addr 0x80 while the slave inserts 3 wait states and returns PRDATA=0x12345678 -> ACCESS lasts 4 cycles; rsp_rdata=0x12345678, rsp_err=0.
3. Push 5 commands with CMD_DEPTH=4 while PREADY=0 -> cmd_ready=0 once 4 are buffered. Release PREADY and hold rsp_ready=1 -> all 5 are issued in order, one transfer every 3 cycles, 5 responses.
4. TIMEOUT=8 with PREADY stuck 0 -> abort after 8 ACCESS cycles; PSEL=0; response with rsp_err=1, rsp_timeout=1, rsp_rdata=0; the next queued command still issues.
5. PSLVERR=1 with PREADY=1 on a write; hold rsp_ready=0 for 10 cycles with a second command queued -> rsp_err=1 held stable; no SETUP until rsp_ready=1, then SETUP in that same cycle's next edge.
6. Assert PRESETN=0 for one cycle mid-ACCESS with 2 commands queued -> next edge PSEL=PENABLE=0, FIFO empty, rsp_valid=0, busy=0; no response for the aborted command.

Source files
------------

// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//   APB3 initiator. Accepts commands on a valid/ready stream into a small
//   FIFO, drives each as one APB SETUP/ACCESS transfer, and returns one held
//   response per command. A stalled slave is aborted after TIMEOUT ACCESS
//   cycles (TIMEOUT=0 waits forever).
//
// Ports
//   PCLK, PRESETN        clock; synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready = not full, out of reset)
//   cmd_write/addr/wdata command payload
//   rsp_valid/rsp_ready  response handshake; response held until consumed
//   rsp_rdata/err/timeout response payload
//   PSEL..PSLVERR        APB3 master interface
//   busy                 FIFO non-empty, transfer in flight, or response held
module apb_cmd_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CMD_DEPTH  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic                  busy
);

    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort fires on the ACCESS cycle whose count would reach TIMEOUT.
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    logic [EW-1:0]         fifo_mem [CMD_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    state_t                state;
    logic [TW-1:0]         tmo_cnt;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  launch;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;

    always_comb begin
        full      = (count == CW'(CMD_DEPTH));
        empty     = (count == '0);
        cmd_ready = PRESETN & ~full;
        push      = cmd_valid & cmd_ready;
        // A held, unconsumed response blocks the next launch so it is never overwritten.
        launch    = (state == IDLE) & ~empty & (~rsp_valid | rsp_ready);
        {head_write, head_addr, head_wdata} = fifo_mem[rd_ptr];
        busy      = ~empty | (state != IDLE) | rsp_valid;
    end

    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            state       <= IDLE;
            tmo_cnt     <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (launch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, launch})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Consumption clears the register; a response loaded below wins.
            if (rsp_valid && rsp_ready) begin
                rsp_valid   <= 1'b0;
                rsp_rdata   <= '0;
                rsp_err     <= 1'b0;
                rsp_timeout <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (launch) begin
                        state   <= SETUP;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PWRITE  <= head_write;
                        PADDR   <= head_addr;
                        PWDATA  <= head_wdata;
                        tmo_cnt <= '0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        state       <= IDLE;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
                            state       <= IDLE;
                            PSEL        <= 1'b0;
                            PENABLE     <= 1'b0;
                            rsp_valid   <= 1'b1;
                            rsp_rdata   <= '0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule
